// File: rtl/sr_drive_ctrl.sv
// Debounced, arbitrated S/R pulse driver for a clocked SR flip-flop; S and R never overlap.
// Latency: raw edge to S/R = DEBOUNCE+2 cycles when idle; no backpressure, requests queue as pending flags.
module sr_drive_ctrl #(
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 8,
  parameter int HOLD     = 1,
  parameter bit PRI_SET  = 1'b1
) (
  input  logic CLK,
  input  logic RST,
  input  logic SET_IN,
  input  logic CLR_IN,
  input  logic Q_FB,
  output logic S,
  output logic R,
  output logic BUSY,
  output logic CONFLICT,
  output logic DROPPED
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] DRIVE_S = 2'd1;
  localparam logic [1:0] DRIVE_R = 2'd2;
  localparam logic [1:0] GAP     = 2'd3;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE - 1);
  localparam logic [3:0]       HOLD_INIT = 4'(HOLD);

  // Bit 0 is the set channel, bit 1 the clear channel.
  logic [1:0]       sync1, sync2, db, db_d, db_n;
  logic [CNT_W-1:0] cnt_set, cnt_clr, cnt_set_n, cnt_clr_n;
  logic [1:0]       rise, pend, pend_eff, pend_n;
  logic [1:0]       state, state_n;
  logic [3:0]       hold, hold_n;
  logic             conflict_n, dropped_n, serve_set;

  always_comb begin
    db_n      = db;
    cnt_set_n = '0;
    cnt_clr_n = '0;
    if (sync2[0] != db[0]) begin
      if (cnt_set == DB_LAST) db_n[0] = sync2[0];
      else                    cnt_set_n = cnt_set + CNT_W'(1);
    end
    if (sync2[1] != db[1]) begin
      if (cnt_clr == DB_LAST) db_n[1] = sync2[1];
      else                    cnt_clr_n = cnt_clr + CNT_W'(1);
    end
  end

  // A fresh edge is arbitrated in the same cycle it is detected, saving a cycle of latency.
  assign rise     = db & ~db_d;
  assign pend_eff = pend | rise;

  always_comb begin
    state_n    = state;
    hold_n     = hold;
    pend_n     = pend_eff;
    conflict_n = 1'b0;
    dropped_n  = 1'b0;
    serve_set  = 1'b0;
    case (state)
      IDLE: begin
        if (pend_eff != 2'b00) begin
          if (pend_eff == 2'b11) begin
            conflict_n = 1'b1;
            serve_set  = PRI_SET;
          end else begin
            serve_set  = pend_eff[0];
          end
          if (serve_set) begin
            pend_n[0] = 1'b0;
            if (Q_FB) dropped_n = 1'b1;
            else begin
              state_n = DRIVE_S;
              hold_n  = HOLD_INIT;
            end
          end else begin
            pend_n[1] = 1'b0;
            if (!Q_FB) dropped_n = 1'b1;
            else begin
              state_n = DRIVE_R;
              hold_n  = HOLD_INIT;
            end
          end
        end
      end
      DRIVE_S, DRIVE_R: begin
        if (hold == 4'd1) begin
          state_n = GAP;
          hold_n  = 4'd0;
        end else begin
          hold_n  = hold - 4'd1;
        end
      end
      GAP:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1    <= 2'b00;
      sync2    <= 2'b00;
      db       <= 2'b00;
      db_d     <= 2'b00;
      cnt_set  <= '0;
      cnt_clr  <= '0;
      pend     <= 2'b00;
      state    <= IDLE;
      hold     <= 4'd0;
      S        <= 1'b0;
      R        <= 1'b0;
      BUSY     <= 1'b0;
      CONFLICT <= 1'b0;
      DROPPED  <= 1'b0;
    end else begin
      sync1    <= {CLR_IN, SET_IN};
      sync2    <= sync1;
      db       <= db_n;
      db_d     <= db;
      cnt_set  <= cnt_set_n;
      cnt_clr  <= cnt_clr_n;
      pend     <= pend_n;
      state    <= state_n;
      hold     <= hold_n;
      S        <= (state_n == DRIVE_S);
      R        <= (state_n == DRIVE_R);
      BUSY     <= (state_n != IDLE);
      CONFLICT <= conflict_n;
      DROPPED  <= dropped_n;
    end
  end

endmodule

// File: doc/sr_drive_ctrl.md
Name: sr_drive_ctrl

Overview:
Upstream driver for the clocked SR flip-flop. Takes two raw, possibly bouncing, asynchronous request lines (set and clear) and produces clean, registered, one-command-at-a-time S/R pulses. S and R are never high together. Q feedback from the flip-flop suppresses redundant commands.

Parameters:
DEBOUNCE, 4, consecutive cycles a synchronized input must hold a new level before it is accepted (1..255)
CNT_W, 8, debounce counter width; must satisfy 2**CNT_W > DEBOUNCE
HOLD, 1, cycles S or R is held high per command (1..15)
PRI_SET, 1, tie-break when set and clear are both pending: 1 = set wins, 0 = clear wins

Ports:
CLK  input  1  system clock; all state updates on rising edge
RST  input  1  synchronous, active-high reset
SET_IN  input  1  raw asynchronous set request (level; rising edge = request)
CLR_IN  input  1  raw asynchronous clear request (level; rising edge = request)
Q_FB  input  1  Q of the downstream SR flip-flop
S  output  1  set drive to the flip-flop (registered)
R  output  1  reset drive to the flip-flop (registered)
BUSY  output  1  high whenever FSM is not IDLE (registered)
CONFLICT  output  1  one-cycle pulse when both requests are pending at an arbitration point
DROPPED  output  1  one-cycle pulse when a request is discarded as redundant per Q_FB

Behaviour:
- Reset (RST=1 at an edge): sync flops, debounced levels, debounce counters, pending flags, hold counter = 0; state = IDLE; S=R=BUSY=CONFLICT=DROPPED=0. RST has priority over every other event, mid-command included; S/R drop to 0 at that same edge.
- Synchronizer: 2 flops per input. Nothing reads the raw inputs directly.
- Debounce, per channel: counter clears when the synced level equals the debounced level. Otherwise it increments. When the synced level has differed for DEBOUNCE consecutive edges, the debounced level takes the synced value and the counter clears. Pulses shorter than DEBOUNCE cycles are ignored.
- Request: rising edge of the debounced level (debounced level vs its 1-cycle delayed copy) sets the channel's pending flag. Falling edges generate nothing.
- Latency: if SET_IN is first sampled high at edge k and the FSM is idle, S goes high at edge k+DEBOUNCE+2 (k+6 at default).
- FSM states: IDLE, DRIVE_S, DRIVE_R, GAP.
  - IDLE, no pending: stay.
  - IDLE, exactly one pending:
    - If set is pending and Q_FB=1, or clear is pending and Q_FB=0: clear that flag, pulse DROPPED, stay in IDLE.
    - Otherwise: clear the flag, go to DRIVE_S or DRIVE_R, load the hold counter with HOLD.
  - IDLE, both pending: pulse CONFLICT. Serve the winner per PRI_SET, including the redundancy check. The loser stays pending and is evaluated after GAP (or on the next cycle if the winner was dropped).
  - DRIVE_S / DRIVE_R: S (resp. R) = 1. Decrement the hold counter; when it reaches 1, go to GAP. S/R are high for exactly HOLD cycles.
  - GAP: S=R=0 for exactly 1 cycle, then IDLE. This gives the flip-flop a settled Q_FB before the next arbitration.
- New request edges during DRIVE_*/GAP set their pending flag. A second edge on an already-pending channel merges; it is not counted twice.
- A request on the channel currently being driven, arriving mid-drive, becomes pending. It is later dropped as redundant if Q_FB reflects it.
- Invariant: S & R == 0 on every cycle. BUSY = (state != IDLE). CONFLICT and DROPPED are high for exactly one cycle per event and can be high simultaneously.

Test Plan:
1. Reset/idle: RST=1 for 2 cycles, then inputs held 0 for 20 cycles -> S=R=BUSY=CONFLICT=DROPPED=0 throughout.
2. Clean set, Q_FB=0, defaults: SET_IN first sampled 1 at edge 10 -> S=1 exactly during cycle after edge 16, BUSY high for 2 cycles (drive + gap), R stays 0.
3. Bounce rejection: SET_IN toggles with high pulses of 3 cycles, DEBOUNCE=4 -> S never asserts; then hold 1 for 6 cycles -> exactly one S pulse.
4. Redundant: Q_FB=1, clean SET_IN edge -> DROPPED pulses once, S stays 0; then CLR_IN edge -> R pulses for HOLD cycles.
5. Conflict: SET_IN and CLR_IN rise on the same edge, Q_FB=0, PRI_SET=1 -> CONFLICT 1 cycle, S pulse; tb drives Q_FB=1 in GAP; then R pulse. With PRI_SET=0 and Q_FB=0 -> clear dropped (DROPPED pulse), then S pulse.
6. Reset mid-drive: HOLD=4, assert RST in the 2nd S-high cycle -> S=0 and BUSY=0 at that edge; pending flags cleared, no pulse after RST release.
